// File: rtl/opc8_bus_pkg.sv
// opc8_bus_pkg: shared state, lane and default sizing constants for the OPC8 SRAM bridge and its SRAM model
package opc8_bus_pkg;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETUP  = 2'd1;
  localparam state_t ST_STROBE = 2'd2;
  localparam state_t ST_DONE   = 2'd3;
  typedef logic [1:0] lane_t;
  localparam int    LANES = 3;
  localparam lane_t LANE0 = 2'd0;
  localparam lane_t LANE1 = 2'd1;
  localparam lane_t LANE2 = 2'd2;
  localparam int DEF_MEM_AW      = 20;
  localparam int DEF_WAIT_CYCLES = 1;
  function automatic logic [7:0] lane_byte(input logic [23:0] w, input lane_t l);
    return l == LANE2 ? w[23:16] : l == LANE1 ? w[15:8] : w[7:0];
  endfunction
endpackage

// File: rtl/opc8_sram_bridge.sv
// opc8_sram_bridge: serves 24-bit OPC8 word requests as three byte accesses to an async SRAM, stalling the CPU via clken
module opc8_sram_bridge
  import opc8_bus_pkg::*;
#(
  parameter int MEM_AW      = DEF_MEM_AW,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              vpa,
  input  logic              vda,
  input  logic              rnw,
  input  logic [23:0]       address,
  input  logic [23:0]       cpu_dout,
  output logic [23:0]       cpu_din,
  output logic              clken,
  output logic [MEM_AW+1:0] mem_addr,
  output logic [7:0]        mem_dq_out,
  output logic              mem_dq_oe,
  input  logic [7:0]        mem_dq_in,
  output logic              mem_ce_b,
  output logic              mem_oe_b,
  output logic              mem_we_b
);
  state_t            state;
  lane_t             lane;
  logic [2:0]        wcnt;
  logic [MEM_AW-1:0] addr_q;
  logic [23:0]       data_q;
  logic              rnw_q;
  logic              done_q;
  logic              req;
  lane_t             lane_nx;
  assign req     = vpa | vda;
  assign clken   = !req | done_q;
  assign lane_nx = lane + 2'd1;
  // SRAM pins are registered, so each is loaded on the edge entering the state that drives it
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state      <= ST_IDLE;
      lane       <= LANE0;
      wcnt       <= 3'd0;
      addr_q     <= '0;
      data_q     <= 24'd0;
      rnw_q      <= 1'b1;
      done_q     <= 1'b0;
      cpu_din    <= 24'd0;
      mem_addr   <= '0;
      mem_dq_out <= 8'd0;
      mem_dq_oe  <= 1'b0;
      mem_ce_b   <= 1'b1;
      mem_oe_b   <= 1'b1;
      mem_we_b   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: if (req) begin
          addr_q    <= address[MEM_AW-1:0];
          data_q    <= cpu_dout;
          rnw_q     <= rnw;
          lane      <= LANE0;
          mem_addr  <= {address[MEM_AW-1:0], LANE0};
          mem_dq_out <= rnw ? mem_dq_out : lane_byte(cpu_dout, LANE0);
          mem_dq_oe <= !rnw;
          mem_ce_b  <= 1'b0;
          state     <= ST_SETUP;
        end
        ST_SETUP: begin
          wcnt     <= 3'(WAIT_CYCLES);
          mem_oe_b <= !rnw_q;
          mem_we_b <= rnw_q;
          state    <= ST_STROBE;
        end
        ST_STROBE: if (wcnt != 3'd0) wcnt <= wcnt - 3'd1;
        else begin
          mem_oe_b <= 1'b1;
          mem_we_b <= 1'b1;
          if (rnw_q) cpu_din[{lane, 3'b000} +: 8] <= mem_dq_in;
          if (lane != LANE2) begin
            lane       <= lane_nx;
            mem_addr   <= {addr_q, lane_nx};
            mem_dq_out <= rnw_q ? mem_dq_out : lane_byte(data_q, lane_nx);
            state      <= ST_SETUP;
          end else begin
            mem_ce_b  <= 1'b1;
            mem_dq_oe <= 1'b0;
            done_q    <= 1'b1;
            state     <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_opc8_sram_bridge.sv
// tb_opc8_sram_bridge: directed checks of two bridges (WAIT_CYCLES 1 and 0), each on a behavioural byte SRAM
module tb_opc8_sram_bridge;
  import opc8_bus_pkg::*;
  logic        clk = 1'b0;
  logic        reset_b [2];
  logic        vpa [2], vda [2], rnw [2];
  logic [23:0] address [2], cpu_dout [2], cpu_din [2];
  logic        clken [2];
  logic [21:0] mem_addr [2];
  logic [7:0]  dq_out [2], dq_in [2];
  logic        dq_oe [2], ce_b [2], oe_b [2], we_b [2];
  logic        pl_en = 1'b0;
  int          pl_k = 0;
  logic [9:0]  pl_a = '0;
  logic [7:0]  pl_d = '0;
  int checks = 0, errors = 0;
  int cyc, pulses, lowc, na, bad;
  logic [21:0] seq [4];
  logic [23:0] din_got;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : gi
    logic [7:0] mem [1024];
    opc8_sram_bridge #(.MEM_AW(20), .WAIT_CYCLES(g == 0 ? 1 : 0)) u_dut (
      .clk(clk), .reset_b(reset_b[g]), .vpa(vpa[g]), .vda(vda[g]), .rnw(rnw[g]),
      .address(address[g]), .cpu_dout(cpu_dout[g]), .cpu_din(cpu_din[g]), .clken(clken[g]),
      .mem_addr(mem_addr[g]), .mem_dq_out(dq_out[g]), .mem_dq_oe(dq_oe[g]), .mem_dq_in(dq_in[g]),
      .mem_ce_b(ce_b[g]), .mem_oe_b(oe_b[g]), .mem_we_b(we_b[g]));
    assign dq_in[g] = mem[mem_addr[g][9:0]];
    always @(posedge clk)
      if (pl_en && pl_k == g) mem[pl_a] <= pl_d;
      else if (!we_b[g] && !ce_b[g] && dq_oe[g]) mem[mem_addr[g][9:0]] <= dq_out[g];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic preload(input int k, input logic [9:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    pl_k = k; pl_a = a; pl_d = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask
  task automatic drive(input int k, input logic p, input logic d, input logic r,
                       input logic [23:0] a, input logic [23:0] w);
    @(posedge clk); #1;
    vpa[k] = p; vda[k] = d; rnw[k] = r; address[k] = a; cpu_dout[k] = w;
  endtask
  task automatic release_req(input int k);
    @(posedge clk); #1;
    vpa[k] = 1'b0; vda[k] = 1'b0; rnw[k] = 1'b1;
  endtask
  task automatic wait_done(input int k);
    logic got, prev_we;
    got = 1'b0; prev_we = 1'b1;
    cyc = 0; pulses = 0; lowc = 0; na = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!we_b[k]) lowc++;
      if (prev_we && !we_b[k]) pulses++;
      prev_we = we_b[k];
      if (!ce_b[k] && na < 4 && (na == 0 || mem_addr[k] != seq[na-1])) begin
        seq[na] = mem_addr[k];
        na++;
      end
      if (clken[k]) begin
        got = 1'b1;
        din_got = cpu_din[k];
      end
    end
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      reset_b[k] = 1'b0; vpa[k] = 1'b1; vda[k] = 1'b0; rnw[k] = 1'b1;
      address[k] = 24'd0; cpu_dout[k] = 24'd0;
    end
    @(negedge clk);
    chk("rst_clken_req", 32'(clken[0]), 32'd0);
    chk("rst_din", 32'(cpu_din[0]), 32'd0);
    chk("rst_addr", 32'(mem_addr[0]), 32'd0);
    chk("rst_strobes", {28'd0, ce_b[0], oe_b[0], we_b[0], dq_oe[0]}, 32'hE);
    chk("rst_dq_out", 32'(dq_out[0]), 32'd0);
    vpa[0] = 1'b0; vpa[1] = 1'b0;
    #1;
    chk("rst_clken_idle", 32'(clken[0]), 32'd1);
    @(posedge clk); #1;
    reset_b[0] = 1'b1; reset_b[1] = 1'b1;
    preload(0, 10'h100, 8'h56);
    preload(0, 10'h101, 8'h34);
    preload(0, 10'h102, 8'h12);
    drive(0, 1'b1, 1'b0, 1'b1, 24'h000040, 24'd0);
    wait_done(0);
    chk("rd_cycles", 32'(cyc), 32'd11);
    chk("rd_data", 32'(din_got), 32'h123456);
    chk("rd_naddr", 32'(na), 32'd3);
    chk("rd_addr0", 32'(seq[0]), 32'h100);
    chk("rd_addr1", 32'(seq[1]), 32'h101);
    chk("rd_addr2", 32'(seq[2]), 32'h102);
    chk("rd_no_we", 32'(pulses), 32'd0);
    release_req(0);
    drive(1, 1'b0, 1'b1, 1'b0, 24'h000007, 24'hA5C3E1);
    wait_done(1);
    chk("wr_cycles", 32'(cyc), 32'd8);
    chk("wr_pulses", 32'(pulses), 32'd3);
    chk("wr_low_cycles", 32'(lowc), 32'd3);
    chk("wr_din_kept", 32'(din_got), 32'd0);
    release_req(1);
    @(negedge clk);
    chk("wr_mem1c", 32'(gi[1].mem[10'h1C]), 32'hE1);
    chk("wr_mem1d", 32'(gi[1].mem[10'h1D]), 32'hC3);
    chk("wr_mem1e", 32'(gi[1].mem[10'h1E]), 32'hA5);
    drive(1, 1'b1, 1'b0, 1'b1, 24'h000007, 24'd0);
    wait_done(1);
    chk("rdback_cycles", 32'(cyc), 32'd8);
    chk("rdback_data", 32'(din_got), 32'hA5C3E1);
    release_req(1);
    drive(0, 1'b1, 1'b0, 1'b1, 24'h000040, 24'd0);
    wait_done(0);
    chk("b2b_first_cycles", 32'(cyc), 32'd11);
    wait_done(0);
    chk("b2b_second_cycles", 32'(cyc), 32'd11);
    chk("b2b_second_data", 32'(din_got), 32'h123456);
    chk("b2b_second_naddr", 32'(na), 32'd3);
    release_req(0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!clken[0] || !ce_b[0] || !oe_b[0] || !we_b[0]) bad++;
    end
    chk("idle_bad_cycles", 32'(bad), 32'd0);
    drive(0, 1'b1, 1'b0, 1'b1, 24'h100040, 24'd0);
    wait_done(0);
    chk("alias_addr0", 32'(seq[0]), 32'h100);
    chk("alias_addr2", 32'(seq[2]), 32'h102);
    chk("alias_data", 32'(din_got), 32'h123456);
    release_req(0);
    preload(1, 10'h040, 8'hEE);
    preload(1, 10'h041, 8'hEE);
    preload(1, 10'h042, 8'hEE);
    drive(1, 1'b0, 1'b1, 1'b0, 24'h000010, 24'h332211);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_lane1_addr", 32'(mem_addr[1]), 32'h41);
    chk("mid_lane1_we", 32'(we_b[1]), 32'd0);
    reset_b[1] = 1'b0; vda[1] = 1'b0; rnw[1] = 1'b1;
    #1;
    chk("mid_rst_strobes", {28'd0, ce_b[1], oe_b[1], we_b[1], dq_oe[1]}, 32'hE);
    chk("mid_rst_din", 32'(cpu_din[1]), 32'd0);
    @(posedge clk); #1;
    reset_b[1] = 1'b1;
    @(negedge clk);
    chk("mid_mem40", 32'(gi[1].mem[10'h040]), 32'h11);
    chk("mid_mem41", 32'(gi[1].mem[10'h041]), 32'hEE);
    chk("mid_mem42", 32'(gi[1].mem[10'h042]), 32'hEE);
    drive(1, 1'b1, 1'b0, 1'b1, 24'h000010, 24'd0);
    wait_done(1);
    chk("post_rst_cycles", 32'(cyc), 32'd8);
    chk("post_rst_data", 32'(din_got), 32'hEEEE11);
    release_req(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
